// File: rtl/alarm_trigger.sv
// alarm_trigger - stored hh:mm:ss alarm compared against the live RTC time,
// rings alarm_active for RING_SECS RTC second transitions. Rev 1.0
`default_nettype none

module alarm_trigger #(
  parameter int RING_SECS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hour_rtc,
  input  logic [5:0] min_rtc,
  input  logic [5:0] sec_rtc,
  input  logic       alarm_set,
  input  logic [4:0] alarm_hour_in,
  input  logic [5:0] alarm_min_in,
  input  logic [5:0] alarm_sec_in,
  output logic       alarm_active
);

  localparam logic [5:0] RING_LOAD = 6'(RING_SECS);

  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [5:0] alarm_sec;
  logic       armed;
  logic       match_prev;
  logic [5:0] sec_prev;
  logic [5:0] ring_cnt;

  logic load_ok;
  logic match;
  logic trigger;
  logic sec_tick;

  assign load_ok = alarm_set && (alarm_hour_in <= 5'd23) &&
                   (alarm_min_in <= 6'd59) && (alarm_sec_in <= 6'd59);

  assign match = armed && (hour_rtc == alarm_hour) &&
                 (min_rtc == alarm_min) && (sec_rtc == alarm_sec);

  // Rising edge of match only, so a held matching second rings once.
  assign trigger  = match && !match_prev && !alarm_set;
  assign sec_tick = (sec_rtc != sec_prev);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm_hour   <= 5'd0;
      alarm_min    <= 6'd0;
      alarm_sec    <= 6'd0;
      armed        <= 1'b0;
      match_prev   <= 1'b0;
      sec_prev     <= 6'd0;
      ring_cnt     <= 6'd0;
      alarm_active <= 1'b0;
    end else begin
      sec_prev <= sec_rtc;
      if (load_ok) begin
        alarm_hour   <= alarm_hour_in;
        alarm_min    <= alarm_min_in;
        alarm_sec    <= alarm_sec_in;
        armed        <= 1'b1;
        match_prev   <= 1'b0;
        ring_cnt     <= 6'd0;
        alarm_active <= 1'b0;
      end else begin
        match_prev <= match;
        if (trigger) begin
          ring_cnt     <= RING_LOAD;
          alarm_active <= 1'b1;
        end else if (alarm_active && sec_tick) begin
          ring_cnt <= ring_cnt - 6'd1;
          if (ring_cnt == 6'd1) begin
            alarm_active <= 1'b0;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alarm_trigger.sv
// tb_alarm_trigger - scoreboard bench for alarm_trigger against a time-of-day model.
`default_nettype none

module tb_alarm_trigger;

  localparam int RING_SECS = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] hour_rtc = '0;
  logic [5:0] min_rtc = '0;
  logic [5:0] sec_rtc = '0;
  logic       alarm_set = 1'b0;
  logic [4:0] alarm_hour_in = '0;
  logic [5:0] alarm_min_in = '0;
  logic [5:0] alarm_sec_in = '0;
  logic       alarm_active;

  alarm_trigger #(.RING_SECS(RING_SECS)) dut (
    .clk          (clk),
    .rst          (rst),
    .hour_rtc     (hour_rtc),
    .min_rtc      (min_rtc),
    .sec_rtc      (sec_rtc),
    .alarm_set    (alarm_set),
    .alarm_hour_in(alarm_hour_in),
    .alarm_min_in (alarm_min_in),
    .alarm_sec_in (alarm_sec_in),
    .alarm_active (alarm_active)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];
  bit rst_drv  = 1'b0;

  // Reference model: alarm time as seconds of day, ring as seconds remaining.
  int m_alarm_t    = 0;
  bit m_armed      = 0;
  bit m_prev_match = 0;
  int m_prev_sec   = 0;
  int m_ring_left  = 0;

  task automatic model_reset();
    m_alarm_t = 0; m_armed = 0; m_prev_match = 0; m_prev_sec = 0; m_ring_left = 0;
  endtask

  task automatic model_step(input int h, input int m, input int s, input bit set,
                            input int ah, input int am, input int asec);
    int  now;
    bit  hit;
    bit  ok;
    now = h * 3600 + m * 60 + s;
    hit = m_armed && (now == m_alarm_t);
    ok  = set && (ah < 24) && (am < 60) && (asec < 60);
    if (ok) begin
      m_alarm_t    = ah * 3600 + am * 60 + asec;
      m_armed      = 1;
      m_ring_left  = 0;
      m_prev_match = 0;
    end else begin
      if (hit && !m_prev_match && !set) m_ring_left = RING_SECS;
      else if (m_ring_left > 0 && s != m_prev_sec) m_ring_left = m_ring_left - 1;
      m_prev_match = hit;
    end
    m_prev_sec = s;
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected output.
  task automatic drive(input int h, input int m, input int s, input bit set = 0,
                       input int ah = 0, input int am = 0, input int asec = 0);
    @(negedge clk);
    rst           = rst_drv;
    hour_rtc      = 5'(h);
    min_rtc       = 6'(m);
    sec_rtc       = 6'(s);
    alarm_set     = set;
    alarm_hour_in = 5'(ah);
    alarm_min_in  = 6'(am);
    alarm_sec_in  = 6'(asec);
    if (!rst_drv) model_reset();
    else model_step(h, m, s, set, ah, am, asec);
    exp_q.push_back(m_ring_left > 0);
  endtask

  task automatic drive_t(input int t, input int cycles);
    for (int k = 0; k < cycles; k++) drive(t / 3600, (t / 60) % 60, t % 60);
  endtask

  // Monitor: one registered output per clock, compared just after the edge.
  initial begin
    bit e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (alarm_active !== e) begin
          n_fail++;
          $display("FAIL alarm_active at %0t: got %b expected %b", $time, alarm_active, e);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: bench did not finish, %0d checks %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int hold;
    int r;
    int at;

    // Reset with arbitrary inputs, then unarmed at 00:00:00.
    rst_drv = 1'b0;
    for (int k = 0; k < 3; k++)
      drive($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59),
            1'($urandom), $urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
    rst_drv = 1'b1;
    drive_t(0, 3);

    // Basic trigger, ring duration, no retrigger on a held second.
    drive(1, 2, 0);
    drive(1, 2, 0, 1, 1, 2, 3);
    drive(1, 2, 1); drive(1, 2, 1);
    drive(1, 2, 2); drive(1, 2, 2);
    drive(1, 2, 3); drive(1, 2, 3); drive(1, 2, 3);
    for (int s = 4; s <= 9; s++) begin
      drive(1, 2, s); drive(1, 2, s);
    end

    // Invalid loads keep the old alarm.
    drive(1, 2, 9, 1, 24, 0, 0);
    drive(1, 2, 9, 1, 1, 2, 60);
    drive(1, 2, 2); drive(1, 2, 3); drive(1, 2, 3); drive(1, 2, 4);

    // Reload while ringing clears, new time rings later.
    drive(1, 2, 4, 1, 5, 0, 0);
    drive(1, 2, 5); drive(1, 2, 6);
    drive(4, 59, 59); drive(4, 59, 59);
    drive(5, 0, 0); drive(5, 0, 0);
    drive(5, 0, 1); drive(5, 0, 2);

    // Load equal to the current time, then async reset mid-ring.
    drive(1, 2, 3);
    drive(1, 2, 3, 1, 1, 2, 3);
    drive(1, 2, 3);
    drive(1, 2, 4);
    @(posedge clk);
    #4;
    n_checks++;
    if (alarm_active !== 1'b1) begin
      n_fail++;
      $display("FAIL ringing_before_reset: got %b expected 1", alarm_active);
    end
    rst = 1'b0;
    rst_drv = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (alarm_active !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_drop: got %b expected 0", alarm_active);
    end
    drive(1, 2, 4); drive(1, 2, 4);
    rst_drv = 1'b1;
    drive(1, 2, 3); drive(1, 2, 3); drive(1, 2, 4);

    // Wrap 23:59:59 -> 00:00:00 with the alarm at midnight.
    drive(23, 59, 58, 1, 0, 0, 0);
    drive_t(86399, 2);
    for (int k = 0; k < 8; k++) drive_t(k, 2);

    // Randomized RTC walk with loads near the current time.
    t = $urandom_range(0, 86399);
    hold = 1;
    for (int i = 0; i < 4000; i++) begin
      hold--;
      if (hold == 0) begin
        t = (t + 1) % 86400;
        hold = $urandom_range(1, 3);
      end
      r = $urandom_range(0, 99);
      if (r < 4) begin
        at = (t + $urandom_range(0, 4)) % 86400;
        drive(t / 3600, (t / 60) % 60, t % 60, 1, at / 3600, (at / 60) % 60, at % 60);
      end else if (r == 4) begin
        drive(t / 3600, (t / 60) % 60, t % 60, 1,
              $urandom_range(24, 31), $urandom_range(0, 63), $urandom_range(60, 63));
      end else begin
        drive(t / 3600, (t / 60) % 60, t % 60);
      end
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alarm_trigger.md
# alarm_trigger

Single-alarm comparator for the RTC clock design. It stores an alarm time (hh:mm:ss) loaded with a one-cycle `alarm_set` strobe and compares it every clock against the live RTC time. On a match it asserts `alarm_active` for a programmable number of RTC seconds. It sits between the RTC counter and the buzzer/LED driver.

## Interface
- `RING_SECS`, default 5: number of RTC second transitions `alarm_active` stays high after a trigger; legal range 1..63.
- `clk`  in  1: system clock (50 MHz in the system).
- `rst`  in  1: asynchronous, active-low reset.
- `hour_rtc`  in  5: current RTC hour, 0..23.
- `min_rtc`  in  6: current RTC minute, 0..59.
- `sec_rtc`  in  6: current RTC second, 0..59.
- `alarm_set`  in  1: load strobe; samples the `alarm_*_in` buses on the clock edge where it is high.
- `alarm_hour_in`  in  5: alarm hour to load.
- `alarm_min_in`  in  6: alarm minute to load.
- `alarm_sec_in`  in  6: alarm second to load.
- `alarm_active`  out  1: alarm ringing indication, registered.

## Operation
- Stored state:
  - alarm hour/min/sec registers
  - `armed` flag
  - `match_prev`
  - `sec_prev`
  - 6-bit `ring_cnt`
  - `alarm_active`
- Load:
  - On a clock edge with `alarm_set`=1 and valid inputs, store the three values, set `armed`=1, clear `alarm_active`, clear `ring_cnt` and clear `match_prev`.
  - Valid inputs: hour ≤ 23, min ≤ 59, sec ≤ 59.
  - Invalid inputs: the whole strobe is ignored and no state changes.
- Compare: `match` = `armed` AND hour/min/sec all equal the stored values. Combinational, from the current inputs and stored registers.
- Trigger condition: `match`=1, `match_prev`=0 and `alarm_set`=0.
  - On that edge: `alarm_active`<=1 and `ring_cnt`<=`RING_SECS`.
  - Edge-detection prevents retriggering while the RTC stays on the matching second.
- Ringing:
  - `sec_prev`<=`sec_rtc` every clock.
  - A second transition is `sec_rtc` ≠ `sec_prev`.
  - While `alarm_active`=1, each second transition decrements `ring_cnt`.
  - When the decrement reaches 0, `alarm_active`<=0 on that edge.
- Priority when events coincide on one edge:
  - `alarm_set` has top priority.
  - A trigger next: it reloads `ring_cnt`, which also covers a retrigger while ringing.
  - Decrement has lowest priority.
- `armed` stays 1 after ringing. The alarm refires every time the RTC passes the stored time again (daily). There is no disarm input; only reset disarms.
- `match_prev`<=`match` every clock, except on a load edge where it is forced to 0.

## Timing
- Reset (`rst`=0, asynchronous) clears all registers: `alarm_active`=0, `armed`=0, stored time = 00:00:00, `ring_cnt`=0, `match_prev`=0, `sec_prev`=0.
- The block leaves reset on the first clock edge after `rst` rises.
- Load latency: the stored time is usable for comparison in the cycle after the `alarm_set` edge.
- Trigger latency: `alarm_active` rises on the first clock edge at which the RTC inputs equal the stored time (one register stage).
- Release: `alarm_active` falls on the clock edge that samples the `RING_SECS`-th second transition after the trigger.
  - With `RING_SECS`=1, it drops on the edge that sees the RTC leave the matching second.
- Loading while the RTC already equals the new time: triggers on the next edge, because `match_prev` was forced to 0.
- Reset mid-ring: `alarm_active` drops immediately (asynchronously) and the alarm is disarmed.
- RTC wrap 23:59:59 -> 00:00:00 is a normal transition; no special handling.

## Test plan
- Reset: `rst`=0 with arbitrary inputs -> `alarm_active`=0. With the RTC at 00:00:00 after release and no load -> still 0, because the block is unarmed.
- Basic trigger:
  - Stimulus: RTC at 01:02:00; load 01:02:03; step sec 1, 2, 3.
  - Response: `alarm_active`=0 through sec 2; rises on the first edge with sec=3.
- Ring duration:
  - Stimulus: `RING_SECS`=5, following the basic trigger; step sec 4..8.
  - Response: `alarm_active` stays high through sec 7; falls on the edge that sees sec=8.
  - No retrigger while sec holds at 3.
- Invalid load: `alarm_set` with hour 24 or sec 60 -> previous alarm retained; RTC reaching the old time still triggers.
- Reload during ringing: `alarm_set` with 05:00:00 while ringing -> `alarm_active` clears next edge. Later, RTC stepping to 05:00:00 -> `alarm_active` rises.
- Load-equals-now and async reset:
  - Load 01:02:03 while the RTC already shows 01:02:03 -> `alarm_active` rises one edge later.
  - Then pulse `rst` low mid-cycle -> `alarm_active` drops immediately.
